// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SAMPLE = 2'd2,
      HOLD   = 2'd3
   } seq_state_t;

   // Operation class, taken from func[3:2]
   localparam logic [1:0] CLS_ARITH = 2'b00;
   localparam logic [1:0] CLS_LOGIC = 2'b01;
   localparam logic [1:0] CLS_CMP   = 2'b10;
   localparam logic [1:0] CLS_SHIFT = 2'b11;

endpackage

// File: rtl/alu_op_sequencer_res_pack.sv
// Result packer: selects the enabled unit's output by class, zero-extends it
// to the result width and reports an error when that unit's flag is low.
module alu_res_pack
   import alu_seq_pkg::*;
#(
   parameter int OP_DATA_WIDTH = 16,
   parameter int RES_WIDTH     = 2 * OP_DATA_WIDTH
) (
   input  logic [1:0]               i_class,
   input  logic [RES_WIDTH-1:0]     i_arith_out,
   input  logic                     i_carry_out,
   input  logic                     i_arith_flag,
   input  logic [OP_DATA_WIDTH-1:0] i_logic_out,
   input  logic                     i_logic_flag,
   input  logic [OP_DATA_WIDTH-1:0] i_shift_out,
   input  logic                     i_shift_flag,
   input  logic [2:0]               i_cmp_out,
   input  logic                     i_cmp_flag,
   output logic [RES_WIDTH-1:0]     o_data,
   output logic                     o_carry,
   output logic                     o_err
);

   logic [RES_WIDTH-1:0] w_raw_data;
   logic                 w_raw_carry;
   logic                 w_flag;

   // Class mux; only the arithmetic unit contributes a carry
   always_comb begin
      w_raw_data  = '0;
      w_raw_carry = 1'b0;
      w_flag      = 1'b0;
      case (i_class)
         CLS_ARITH: begin
            w_raw_data  = i_arith_out;
            w_raw_carry = i_carry_out;
            w_flag      = i_arith_flag;
         end
         CLS_LOGIC: begin
            w_raw_data = {{(RES_WIDTH-OP_DATA_WIDTH){1'b0}}, i_logic_out};
            w_flag     = i_logic_flag;
         end
         CLS_CMP: begin
            w_raw_data = {{(RES_WIDTH-3){1'b0}}, i_cmp_out};
            w_flag     = i_cmp_flag;
         end
         default: begin
            w_raw_data = {{(RES_WIDTH-OP_DATA_WIDTH){1'b0}}, i_shift_out};
            w_flag     = i_shift_flag;
         end
      endcase
   end

   // A missing unit flag means the output is not trustworthy: zero it and flag an error
   always_comb begin
      o_err   = ~w_flag;
      o_data  = w_flag ? w_raw_data : '0;
      o_carry = w_flag ? w_raw_carry : 1'b0;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for ALU_TOP: accepts one command per handshake, drives
// the registered ALU inputs, samples the flag-qualified result two edges
// later and holds it on a valid/ready result port until consumed.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int OP_DATA_WIDTH = 16,
   parameter int RES_WIDTH     = 2 * OP_DATA_WIDTH,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_func,
   input  logic [OP_DATA_WIDTH-1:0] cmd_a,
   input  logic [OP_DATA_WIDTH-1:0] cmd_b,
   output logic [OP_DATA_WIDTH-1:0] alu_a,
   output logic [OP_DATA_WIDTH-1:0] alu_b,
   output logic [3:0]               alu_func,
   input  logic [RES_WIDTH-1:0]     arith_out,
   input  logic                     carry_out,
   input  logic                     arith_flag,
   input  logic [OP_DATA_WIDTH-1:0] logic_out,
   input  logic                     logic_flag,
   input  logic [OP_DATA_WIDTH-1:0] shift_out,
   input  logic                     shift_flag,
   input  logic [2:0]               cmp_out,
   input  logic                     cmp_flag,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [RES_WIDTH-1:0]     res_data,
   output logic                     res_carry,
   output logic [1:0]               res_class,
   output logic                     res_err,
   output logic                     busy,
   output logic [CNT_WIDTH-1:0]     ops_done
);

   seq_state_t               r_state;
   logic [OP_DATA_WIDTH-1:0] r_alu_a;
   logic [OP_DATA_WIDTH-1:0] r_alu_b;
   logic [3:0]               r_alu_func;
   logic [1:0]               r_class;
   logic                     r_cmd_ready;
   logic                     r_busy;
   logic                     r_res_valid;
   logic [RES_WIDTH-1:0]     r_res_data;
   logic                     r_res_carry;
   logic [1:0]               r_res_class;
   logic                     r_res_err;
   logic [CNT_WIDTH-1:0]     r_ops_done;

   logic [RES_WIDTH-1:0]     w_pack_data;
   logic                     w_pack_carry;
   logic                     w_pack_err;

   // The packer looks at the class latched at accept, so the mux is stable
   // through ISSUE and SAMPLE regardless of new command traffic
   alu_res_pack #(
      .OP_DATA_WIDTH (OP_DATA_WIDTH),
      .RES_WIDTH     (RES_WIDTH)
   ) u_res_pack (
      .i_class      (r_class),
      .i_arith_out  (arith_out),
      .i_carry_out  (carry_out),
      .i_arith_flag (arith_flag),
      .i_logic_out  (logic_out),
      .i_logic_flag (logic_flag),
      .i_shift_out  (shift_out),
      .i_shift_flag (shift_flag),
      .i_cmp_out    (cmp_out),
      .i_cmp_flag   (cmp_flag),
      .o_data       (w_pack_data),
      .o_carry      (w_pack_carry),
      .o_err        (w_pack_err)
   );

   // Sequencer FSM with all outputs registered alongside the state
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= IDLE;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_func  <= '0;
         r_class     <= '0;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_carry <= 1'b0;
         r_res_class <= '0;
         r_res_err   <= 1'b0;
         r_ops_done  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_alu_a     <= cmd_a;
                  r_alu_b     <= cmd_b;
                  r_alu_func  <= cmd_func;
                  r_class     <= cmd_func[3:2];
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ISSUE;
               end
            end
            // ALU registers its outputs at the end of this cycle
            ISSUE: begin
               r_state <= SAMPLE;
            end
            // Only here are the ALU outputs known to belong to this command
            SAMPLE: begin
               r_res_data  <= w_pack_data;
               r_res_carry <= w_pack_carry;
               r_res_err   <= w_pack_err;
               r_res_class <= r_class;
               r_res_valid <= 1'b1;
               r_state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_ops_done  <= r_ops_done + CNT_WIDTH'(1);
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_func  = r_alu_func;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_carry = r_res_carry;
   assign res_class = r_res_class;
   assign res_err   = r_res_err;
   assign busy      = r_busy;
   assign ops_done  = r_ops_done;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

- Command front-end that drives the `ALU_TOP` operand/function inputs and collects its registered, flag-qualified outputs.
- Accepts one operation per valid/ready command handshake, presents it to the ALU, and samples the result when it is valid.
- Packs the output of the enabled unit into one result word and holds it on a valid/ready result port until consumed.
- Sits between the system register file/controller and `ALU_TOP`.

## Interface

- `OP_DATA_WIDTH`, 16, operand width; must match `ALU_TOP`.
- `RES_WIDTH`, 2*OP_DATA_WIDTH, packed result width.
- `CNT_WIDTH`, 16, completed-operation counter width.

Ports:

- `CLK` in 1: the single clock.
- `RST` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_func` in 4: ALU function code.
- `cmd_a`, `cmd_b` in OP_DATA_WIDTH: operands.
- `alu_a`, `alu_b` out OP_DATA_WIDTH: registered, drive `A`/`B`.
- `alu_func` out 4: registered, drives `ALU_FUNC`.
- `arith_out` in RES_WIDTH; `carry_out`, `arith_flag` in 1.
- `logic_out` in OP_DATA_WIDTH; `logic_flag` in 1.
- `shift_out` in OP_DATA_WIDTH; `shift_flag` in 1.
- `cmp_out` in 3; `cmp_flag` in 1.
- `res_valid` out 1; `res_ready` in 1.
- `res_data` out RES_WIDTH: packed result.
- `res_carry` out 1: carry, arithmetic class only.
- `res_class` out 2: copy of `func[3:2]`.
- `res_err` out 1: expected flag was low at sample.
- `busy` out 1: state ≠ IDLE.
- `ops_done` out CNT_WIDTH: count of completed results.

## Operation

Class decode is `func[3:2]`: 00 arith, 01 logic, 10 compare, 11 shift.

FSM states:

- **IDLE**: `cmd_ready` = 1. On `cmd_valid` && `cmd_ready`, load `alu_a`/`alu_b`/`alu_func` from the command, latch the class, go to ISSUE.
- **ISSUE**: one cycle; the ALU registers its outputs at the end of this cycle. Go to SAMPLE.
- **SAMPLE**: one cycle. Capture the packed result and go to HOLD.
  - If the class flag is high, capture normally.
  - Otherwise set `res_err` = 1 and `res_data` = 0.
- **HOLD**: `res_valid` = 1, outputs stable. On `res_ready`, increment `ops_done` and go to IDLE.

Packing:

- Arith: `res_data` = `arith_out`; `res_carry` = `carry_out`.
- Logic/shift: `res_data` = zero-extended unit output; `res_carry` = 0.
- Compare: `res_data` = zero-extended `cmp_out` (3 bits); `res_carry` = 0.

Handshake and counter rules:

- `cmd_ready` is low outside IDLE.
- `cmd_valid` asserted in non-IDLE states is ignored and not consumed.
- `alu_a`/`alu_b`/`alu_func` hold their last command until the next accept.
- `ops_done` wraps from all-ones to 0.
- `res_ready` outside HOLD has no effect.

## Timing

- Reset values:
  - State = IDLE.
  - `cmd_ready` = 1 on the cycle after reset.
  - `res_valid`, `res_err`, `res_carry`, `busy` = 0.
  - `res_data`, `res_class`, `alu_a`, `alu_b`, `alu_func`, `ops_done` = 0.
- Accept at edge N:
  - ALU inputs change after edge N.
  - ALU registers its outputs at edge N+1.
  - Sequencer captures at edge N+2.
  - `res_valid` is high from edge N+2.
- `res_valid` && `res_ready` at edge M: `res_valid` falls and `cmd_ready` rises after M.
  - Next accept is possible at edge M+1.
  - Minimum period is 4 cycles per operation.
- A back-to-back command of the same class is still sampled only in SAMPLE, so stale held outputs are never captured.
- `RST` at any edge, including during ISSUE, SAMPLE or HOLD:
  - The in-flight operation is discarded without incrementing `ops_done`.
  - All outputs take their reset values after that edge.
- `res_ready` held high continuously: each result is valid for exactly one cycle.

## Structure

- Package `alu_seq_pkg` holds:
  - State enum: IDLE, ISSUE, SAMPLE, HOLD.
  - Class constants: CLS_ARITH = 2'b00, CLS_LOGIC = 2'b01, CLS_CMP = 2'b10, CLS_SHIFT = 2'b11.
- Sub-module `alu_res_pack`: combinational class mux, zero-extension and flag select. It is instantiated once; FSM and registers stay in the top.

## Test plan

- **Arith add**: `cmd_func` = 4'b0000, `cmd_a` = 0xFFFF, `cmd_b` = 0x0001, ALU model driving `arith_out` = 0x0001_0000 and `arith_flag` = 1.
  - `res_valid` two edges after accept.
  - `res_data` = 0x00010000, `res_class` = 0, `res_err` = 0.
- **Logic**: `cmd_func` = 4'b0100, model `logic_out` = 0x00F0.
  - `res_data` = 0x000000F0, `res_carry` = 0, `res_class` = 1.
- **Compare**: `cmd_func` = 4'b1001, model `cmp_out` = 3'b010.
  - `res_data` = 0x00000002, `res_class` = 2.
- **Flag fault**: shift command with model `shift_flag` forced 0.
  - `res_err` = 1, `res_data` = 0, `ops_done` still increments on consume.
- **Backpressure**: `res_ready` = 0 for 10 cycles.
  - `res_valid`, `res_data` and `cmd_ready` = 0 stay stable.
  - A second `cmd_valid` is not consumed.
  - Release: exactly one transfer, `cmd_ready` = 1 next cycle.
- **Reset mid-op**: `RST` pulsed in SAMPLE.
  - All outputs at reset values.
  - `ops_done` = 0; the next command completes normally.
